// File: rtl/johnson_code_monitor.sv
// Johnson code monitor: decodes a stream of 4-bit Johnson counter values,
// tracks step-by-step sequencing through HUNT / ACQUIRE / LOCKED states and
// reports illegal codes, sequence breaks and 7->0 wraps. Every output is
// registered and appears exactly one clock after the sampling edge.
// Optional feature: define JOHNSON_MON_ERRCNT_EN to build a saturating
// 8-bit error counter; without it err_count is tied to zero.
module johnson_code_monitor #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [3:0] code,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic       locked,
  output logic       illegal_err,
  output logic       seq_err,
  output logic       wrap,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT_C   = LOCK_CNT[3:0];
  localparam logic [3:0] UNLOCK_CNT_C = UNLOCK_CNT[3:0];

  // Returns {legal, step}; step is 0 for the eight non-Johnson patterns.
  function automatic logic [3:0] decode_johnson(input logic [3:0] c);
    logic [3:0] result;
    case (c)
      4'b0000: result = {1'b1, 3'd0};
      4'b0001: result = {1'b1, 3'd1};
      4'b0011: result = {1'b1, 3'd2};
      4'b0111: result = {1'b1, 3'd3};
      4'b1111: result = {1'b1, 3'd4};
      4'b1110: result = {1'b1, 3'd5};
      4'b1100: result = {1'b1, 3'd6};
      4'b1000: result = {1'b1, 3'd7};
      default: result = {1'b0, 3'd0};
    endcase
    return result;
  endfunction

  state_t     r_state;
  logic [2:0] r_ref_phase;
  logic [3:0] r_good;
  logic [3:0] r_bad;
  logic [2:0] r_phase;
  logic       r_phase_valid;
  logic       r_locked;
  logic       r_illegal_err;
  logic       r_seq_err;
  logic       r_wrap;

  state_t     w_state_nxt;
  logic [2:0] w_ref_phase_nxt;
  logic [3:0] w_good_nxt;
  logic [3:0] w_bad_nxt;
  logic [2:0] w_phase_nxt;
  logic       w_phase_valid;
  logic       w_illegal_err;
  logic       w_seq_err;
  logic       w_wrap;

  logic [3:0] w_dec;
  logic       w_legal;
  logic [2:0] w_dec_phase;
  logic [2:0] w_expected;
  logic       w_in_seq;
  logic [3:0] w_good_inc;
  logic [3:0] w_bad_inc;

  assign w_dec       = decode_johnson(code);
  assign w_legal     = w_dec[3];
  assign w_dec_phase = w_dec[2:0];
  assign w_expected  = r_ref_phase + 3'd1;
  assign w_in_seq    = w_legal && (w_dec_phase == w_expected);
  assign w_good_inc  = r_good + 4'd1;
  assign w_bad_inc   = r_bad + 4'd1;

  // Next-state and next-output logic for one sampled code.
  always_comb begin
    w_state_nxt     = r_state;
    w_ref_phase_nxt = r_ref_phase;
    w_good_nxt      = r_good;
    w_bad_nxt       = r_bad;
    w_phase_nxt     = r_phase;
    w_phase_valid   = 1'b0;
    w_illegal_err   = 1'b0;
    w_seq_err       = 1'b0;
    w_wrap          = 1'b0;
    if (code_valid) begin
      // phase follows every legal code regardless of tracking state
      if (w_legal) begin
        w_phase_nxt   = w_dec_phase;
        w_phase_valid = 1'b1;
      end else begin
        w_phase_nxt   = r_phase;
        w_phase_valid = 1'b0;
      end
      case (r_state)
        ST_HUNT: begin
          if (w_legal) begin
            w_ref_phase_nxt = w_dec_phase;
            w_good_nxt      = 4'd0;
            w_state_nxt     = ST_ACQUIRE;
          end else begin
            w_illegal_err = 1'b1;
          end
        end
        ST_ACQUIRE: begin
          if (w_in_seq) begin
            w_ref_phase_nxt = w_dec_phase;
            w_good_nxt      = w_good_inc;
            if (w_good_inc == LOCK_CNT_C) begin
              w_state_nxt = ST_LOCKED;
              w_bad_nxt   = 4'd0;
            end else begin
              w_state_nxt = ST_ACQUIRE;
            end
          end else if (w_legal) begin
            // restart acquisition anchored on the new code
            w_seq_err       = 1'b1;
            w_ref_phase_nxt = w_dec_phase;
            w_good_nxt      = 4'd0;
          end else begin
            w_illegal_err = 1'b1;
            w_state_nxt   = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (w_in_seq) begin
            w_bad_nxt       = 4'd0;
            w_ref_phase_nxt = w_dec_phase;
            w_wrap          = (r_ref_phase == 3'd7);
          end else begin
            if (w_legal) begin
              // resync the reference to the observed code
              w_seq_err       = 1'b1;
              w_ref_phase_nxt = w_dec_phase;
            end else begin
              w_illegal_err = 1'b1;
            end
            w_bad_nxt = w_bad_inc;
            if (w_bad_inc == UNLOCK_CNT_C) begin
              w_state_nxt = ST_HUNT;
            end else begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, tracking counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_ref_phase   <= 3'd0;
      r_good        <= 4'd0;
      r_bad         <= 4'd0;
      r_phase       <= 3'd0;
      r_phase_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_illegal_err <= 1'b0;
      r_seq_err     <= 1'b0;
      r_wrap        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ref_phase   <= w_ref_phase_nxt;
      r_good        <= w_good_nxt;
      r_bad         <= w_bad_nxt;
      r_phase       <= w_phase_nxt;
      r_phase_valid <= w_phase_valid;
      r_locked      <= (w_state_nxt == ST_LOCKED);
      r_illegal_err <= w_illegal_err;
      r_seq_err     <= w_seq_err;
      r_wrap        <= w_wrap;
    end
  end

`ifdef JOHNSON_MON_ERRCNT_EN
  logic [7:0] r_err_count;

  // Saturating count of registered error pulses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if ((w_illegal_err || w_seq_err) && (r_err_count != 8'd255)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign phase       = r_phase;
  assign phase_valid = r_phase_valid;
  assign locked      = r_locked;
  assign illegal_err = r_illegal_err;
  assign seq_err     = r_seq_err;
  assign wrap        = r_wrap;

endmodule

// File: tb/tb_johnson_code_monitor.sv
// Bench for johnson_code_monitor: directed scenarios with literal expectations
// followed by randomized stimulus checked every cycle against a step-list model.
module tb_johnson_code_monitor;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [3:0] code;
  logic [2:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       illegal_err;
  logic       seq_err;
  logic       wrap;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // model state
  int m_mode;    // 0 = hunting, 1 = acquiring, 2 = locked
  int m_anchor;  // last reference step
  int m_good;
  int m_bad;
  int m_phase;
  int m_err;
  // expected outputs after the next edge
  int e_phase, e_pv, e_locked, e_ill, e_seq, e_wrap, e_err;

  johnson_code_monitor #(.LOCK_CNT(3), .UNLOCK_CNT(2)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .phase(phase), .phase_valid(phase_valid), .locked(locked),
    .illegal_err(illegal_err), .seq_err(seq_err), .wrap(wrap),
    .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Johnson pattern of step k: k ones filling from the LSB, then zeros from the LSB.
  function automatic logic [3:0] jcode(input int k);
    int v;
    if (k <= 4) v = (1 << k) - 1;
    else v = (15 << (k - 4)) & 15;
    return v[3:0];
  endfunction

  function automatic int jstep(input logic [3:0] c);
    for (int i = 0; i < 8; i++) begin
      if (jcode(i) == c) return i;
    end
    return -1;
  endfunction

  function automatic int bump_err(input int cnt);
`ifdef JOHNSON_MON_ERRCNT_EN
    return (cnt < 255) ? cnt + 1 : 255;
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input logic rst, input logic v, input logic [3:0] c);
    int idx;
    bit in_seq;
    if (rst) begin
      m_mode = 0; m_anchor = 0; m_good = 0; m_bad = 0; m_phase = 0; m_err = 0;
      e_phase = 0; e_pv = 0; e_locked = 0; e_ill = 0; e_seq = 0; e_wrap = 0; e_err = 0;
      return;
    end
    e_pv = 0; e_ill = 0; e_seq = 0; e_wrap = 0;
    if (v) begin
      idx = jstep(c);
      in_seq = (idx >= 0) && (idx == (m_anchor + 1) % 8);
      if (idx >= 0) begin
        m_phase = idx;
        e_pv = 1;
      end
      if (m_mode == 0) begin
        if (idx >= 0) begin m_anchor = idx; m_good = 0; m_mode = 1; end
        else e_ill = 1;
      end else if (m_mode == 1) begin
        if (in_seq) begin
          m_anchor = idx; m_good++;
          if (m_good == 3) begin m_mode = 2; m_bad = 0; end
        end else if (idx >= 0) begin
          e_seq = 1; m_anchor = idx; m_good = 0;
        end else begin
          e_ill = 1; m_mode = 0;
        end
      end else begin
        if (in_seq) begin
          e_wrap = (m_anchor == 7) ? 1 : 0;
          m_anchor = idx; m_bad = 0;
        end else begin
          if (idx >= 0) begin e_seq = 1; m_anchor = idx; end
          else e_ill = 1;
          m_bad++;
          if (m_bad == 2) m_mode = 0;
        end
      end
      if (e_ill == 1 || e_seq == 1) m_err = bump_err(m_err);
    end
    e_phase = m_phase;
    e_locked = (m_mode == 2) ? 1 : 0;
    e_err = m_err;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("phase", int'(phase), e_phase);
    chk("phase_valid", int'(phase_valid), e_pv);
    chk("locked", int'(locked), e_locked);
    chk("illegal_err", int'(illegal_err), e_ill);
    chk("seq_err", int'(seq_err), e_seq);
    chk("wrap", int'(wrap), e_wrap);
    chk("err_count", int'(err_count), e_err);
    chk("err_exclusive", int'(illegal_err & seq_err), 0);
  endtask

  // one clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic cycle(input logic rst, input logic v, input logic [3:0] c);
    reset = rst;
    code_valid = v;
    code = c;
    model_step(rst, v, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic feed(input logic [3:0] c);
    cycle(1'b0, 1'b1, c);
  endtask

  initial begin
    int max_err;
    int r;
    int nxt;
    logic [3:0] c;
    reset = 1'b1; code_valid = 1'b0; code = 4'b0000;
`ifdef JOHNSON_MON_ERRCNT_EN
    max_err = 255;
`else
    max_err = 0;
`endif

    // reset state
    cycle(1'b1, 1'b0, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0101);
    chk("lit_reset_phase", int'(phase), 0);
    chk("lit_reset_locked", int'(locked), 0);

    // acquire and lock
    feed(4'b0000); chk("lit_acq_phase0", int'(phase), 0); chk("lit_acq_lock0", int'(locked), 0);
    feed(4'b0001); chk("lit_acq_phase1", int'(phase), 1);
    feed(4'b0011); chk("lit_acq_phase2", int'(phase), 2); chk("lit_acq_lock2", int'(locked), 0);
    feed(4'b0111); chk("lit_acq_phase3", int'(phase), 3); chk("lit_lock", int'(locked), 1);

    // illegal while locked, then recover in sequence
    feed(4'b0101); chk("lit_ill_pulse", int'(illegal_err), 1); chk("lit_ill_keeplock", int'(locked), 1);
    chk("lit_ill_phase_hold", int'(phase), 3);
    feed(4'b1111); chk("lit_recover_phase", int'(phase), 4); chk("lit_recover_ill", int'(illegal_err), 0);

    // wrap from 7 to 0
    feed(4'b1110);
    feed(4'b1100);
    feed(4'b1000); chk("lit_nowrap7", int'(wrap), 0);
    feed(4'b0000); chk("lit_wrap", int'(wrap), 1); chk("lit_wrap_phase", int'(phase), 0);
    feed(4'b0001); chk("lit_wrap_once", int'(wrap), 0);

    // two sequence errors drop lock
    cycle(1'b1, 1'b0, 4'b0000);
    feed(4'b1000); feed(4'b0000); feed(4'b0001); feed(4'b0011);
    chk("lit_lock_at2", int'(locked), 1);
    feed(4'b1110); chk("lit_seq1", int'(seq_err), 1); chk("lit_seq1_lock", int'(locked), 1);
    feed(4'b1000); chk("lit_seq2", int'(seq_err), 1); chk("lit_seq2_unlock", int'(locked), 0);
`ifdef JOHNSON_MON_ERRCNT_EN
    chk("lit_errcnt2", int'(err_count), 2);
`else
    chk("lit_errcnt2", int'(err_count), 0);
`endif

    // mid-stream reset, then re-acquire
    cycle(1'b1, 1'b0, 4'b0000);
    feed(4'b0000); feed(4'b0001); feed(4'b0011); feed(4'b0111);
    cycle(1'b1, 1'b1, 4'b1111);
    chk("lit_mid_rst_locked", int'(locked), 0);
    chk("lit_mid_rst_phase", int'(phase), 0);
    chk("lit_mid_rst_pv", int'(phase_valid), 0);
    feed(4'b0011); chk("lit_reacq_pv", int'(phase_valid), 1); chk("lit_reacq_seq", int'(seq_err), 0);
    feed(4'b0111); chk("lit_reacq_seq2", int'(seq_err), 0); chk("lit_reacq_unlocked", int'(locked), 0);

    // idle cycles hold phase and clear pulses
    cycle(1'b0, 1'b0, 4'b0101);
    chk("lit_idle_phase", int'(phase), 3);
    chk("lit_idle_pv", int'(phase_valid), 0);

    // saturation with illegal codes
    for (int i = 0; i < 300; i++) begin
      feed((i % 2 == 0) ? 4'b0101 : 4'b1010);
    end
    chk("lit_err_sat", int'(err_count), max_err);

    // randomized stream
    cycle(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      nxt = (m_anchor + 1) % 8;
      if (r < 2) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (r < 15) begin
        cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end else if (r < 70) begin
        feed(jcode(nxt));
      end else if (r < 85) begin
        feed(jcode(int'($urandom_range(0, 7))));
      end else begin
        c = 4'($urandom_range(0, 15));
        feed(c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_code_monitor.md
JOHNSON_CODE_MONITOR -- requirements
Module: johnson_code_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 3: number of consecutive in-sequence codes needed after the first legal code to assert lock (range 1..15).
REQ-002 Parameter UNLOCK_CNT, default 2: number of consecutive errors while locked that drop lock (range 1..15).
REQ-003 clk  input  1  clock; all logic SHALL be sensitive to its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 code_valid  input  1  code is sampled on a rising edge only when this is high.
REQ-006 code  input  4  observed 4-bit Johnson counter value.
REQ-007 phase  output  3  decoded step index 0..7 of the last legal code.
REQ-008 phase_valid  output  1  one-cycle pulse; phase was updated from a legal code.
REQ-009 locked  output  1  level; the monitor is tracking a correct sequence.
REQ-010 illegal_err  output  1  one-cycle pulse; sampled code is not one of the 8 Johnson codes.
REQ-011 seq_err  output  1  one-cycle pulse; a legal code was not the expected successor.
REQ-012 wrap  output  1  one-cycle pulse; a locked in-sequence step from phase 7 to phase 0.
REQ-013 err_count  output  8  saturating error counter (see Configuration).

Function
REQ-014 The decode table SHALL be 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; all other 8 codes are illegal.
REQ-015 All outputs SHALL be registered with a latency of exactly 1 clk from the sampling edge.
REQ-016 When code_valid is low: no state change, phase holds, and all pulse outputs are 0 on the next cycle.
REQ-017 Expected successor = (ref_phase + 1) mod 8; repeating the same code counts as out-of-sequence.
REQ-018 FSM states: HUNT, ACQUIRE, LOCKED; locked is high only in LOCKED.
REQ-019 HUNT, legal code: ref_phase <= decode, good <= 0, go to ACQUIRE, no seq_err. HUNT, illegal code: illegal_err, stay.
REQ-020 ACQUIRE, in-sequence: good++; when good reaches LOCK_CNT, go to LOCKED with bad <= 0.
REQ-021 ACQUIRE, out-of-sequence legal: seq_err, ref_phase <= decode, good <= 0, stay. ACQUIRE, illegal: illegal_err, go to HUNT.
REQ-022 LOCKED, in-sequence: bad <= 0, ref advances; wrap SHALL pulse when the step is 7->0.
REQ-023 LOCKED, out-of-sequence legal: seq_err, bad++, ref_phase <= decode (resync). LOCKED, illegal: illegal_err, bad++, ref_phase unchanged.
REQ-024 LOCKED: when bad reaches UNLOCK_CNT, go to HUNT; locked deasserts on the same edge that registers the terminating error pulse.
REQ-025 phase and phase_valid SHALL update on every legal sampled code in every state; illegal codes SHALL NOT alter phase.
REQ-026 illegal_err and seq_err SHALL never assert in the same cycle.

Reset
REQ-027 While reset is high at a rising edge: state <= HUNT, phase <= 0, ref_phase <= 0, good <= 0, bad <= 0, all pulses <= 0, locked <= 0, err_count <= 0.
REQ-028 Reset SHALL take priority over code_valid, and mid-sequence reset SHALL discard lock with no error pulse.

Configuration
REQ-029 Macro JOHNSON_MON_ERRCNT_EN defined: err_count increments by 1 on each cycle that registers illegal_err or seq_err, saturates at 255, and is cleared only by reset.
REQ-030 Macro JOHNSON_MON_ERRCNT_EN undefined: err_count SHALL be a constant 0, with no counter flops.

Verification
REQ-031 Reset, then valid codes 0000,0001,0011,0111 -> locked = 1 one cycle after the 0111 sample; phase = 0,1,2,3; no error pulses.
REQ-032 Locked; feed 1100,1000,0000 -> wrap pulses once, on the cycle that registers phase 0.
REQ-033 Locked at phase 3; feed 0101 then 1111 -> illegal_err on 0101; the locked state holds (bad = 1); 1111 is in-sequence, so bad returns to 0.
REQ-034 Locked at phase 2; feed 1110, then 1000 -> two seq_err pulses; locked drops after the second; with the macro defined, err_count = 2.
REQ-035 Locked, then reset asserted for 1 cycle mid-stream -> all outputs 0, state HUNT; the next legal code enters ACQUIRE.
REQ-036 With the macro defined, 300 illegal codes -> err_count saturates at 255; with the macro undefined, err_count stays 0.
